// File: rtl/popcount_seq.sv
// popcount_seq: sequential ones-counter over a WIDTH-bit word.
// It consumes STEP bits per clock and reports the ones-count, a strict
// majority flag and a parity flag through a start/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only in IDLE or DONE
//   din    word to count, captured on the accepting edge
//   busy   high while the word is being consumed
//   done   one-cycle pulse, results valid
//   count  number of ones in the captured word
//   maj    count > WIDTH/2
//   par    XOR of all captured bits
module popcount_seq #(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             maj,
  output logic             par
);

  localparam int N  = WIDTH / STEP;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_q, shift_nx;
  logic [CW-1:0]    acc_q, acc_nx;
  logic [SW-1:0]    step_q, step_nx;
  logic [CW-1:0]    step_pc;
  logic [CW-1:0]    sum;
  logic             busy_nx, done_nx, maj_nx, par_nx;
  logic [CW-1:0]    count_nx;

  // Ones in the low STEP bits of the shift register, plus the running total.
  always_comb begin
    step_pc = '0;
    for (int unsigned i = 0; i < unsigned'(STEP); i++) begin
      step_pc = step_pc + CW'(shift_q[i]);
    end
    sum = acc_q + step_pc;
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift_q;
    acc_nx   = acc_q;
    step_nx  = step_q;
    count_nx = count;
    maj_nx   = maj;
    par_nx   = par;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;

    case (state)
      IDLE, DONE: begin
        // DONE accepts a new word directly so back-to-back words need no IDLE gap.
        if (start) begin
          state_nx = RUN;
          shift_nx = din;
          acc_nx   = '0;
          step_nx  = '0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end

      RUN: begin
        acc_nx = sum;
        if (step_q == LAST) begin
          // Final slice: results are derived from the full sum on this same edge.
          state_nx = DONE;
          done_nx  = 1'b1;
          count_nx = sum;
          maj_nx   = (sum > HALF);
          par_nx   = sum[0];
        end else begin
          busy_nx  = 1'b1;
          shift_nx = shift_q >> STEP;
          step_nx  = step_q + SW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      maj     <= 1'b0;
      par     <= 1'b0;
    end else begin
      state   <= state_nx;
      shift_q <= shift_nx;
      acc_q   <= acc_nx;
      step_q  <= step_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      count   <= count_nx;
      maj     <= maj_nx;
      par     <= par_nx;
    end
  end

endmodule
